// File: rtl/toggle_edge_collector_if.sv
`default_nettype none
// ============================================================================
// toggle_edge_collector_if : monitored vector, first-hit pulses, index stream
// Revision: 1.0
// ============================================================================
interface toggle_edge_collector_if #(
   parameter int WIDTH = 52
);
   localparam int NPTS  = 2 * WIDTH;
   localparam int CNT_W = $clog2(NPTS + 1);

   logic [WIDTH-1:0] sig;
   logic             clear;
   logic [NPTS-1:0]  valid;
   logic             idx_valid;
   logic             idx_ready;
   logic [63:0]      idx;
   logic [CNT_W-1:0] covered_cnt;
   logic             all_covered;

   modport master (
      output sig, clear, idx_ready,
      input  valid, idx_valid, idx, covered_cnt, all_covered
   );

   modport slave (
      input  sig, clear, idx_ready,
      output valid, idx_valid, idx, covered_cnt, all_covered
   );
endinterface
`default_nettype wire

// File: rtl/toggle_edge_collector.sv
`default_nettype none
// ============================================================================
// toggle_edge_collector : sticky per-bit rise/fall cover with first-hit pulses
// and an optional serial index drain (enabled by TOGGLE_INDEX_STREAM_EN).
// Revision: 1.0
// ============================================================================
module toggle_edge_collector #(
   parameter int          WIDTH       = 52,
   parameter logic [63:0] COVER_INDEX = 64'd0,
   parameter logic [63:0] COVER_TOTAL = 64'd28338
) (
   input  wire logic              gbl_clk,
   input  wire logic              reset,
   toggle_edge_collector_if.slave bus
);
   localparam int NPTS  = 2 * WIDTH;
   localparam int CNT_W = $clog2(NPTS + 1);
   localparam int POS_W = (NPTS > 1) ? $clog2(NPTS) : 1;

   generate
      if (COVER_INDEX + 64'(NPTS) > COVER_TOTAL) begin : g_bad_cover_range
         $error("toggle_edge_collector: COVER_INDEX + 2*WIDTH exceeds COVER_TOTAL");
      end
   endgenerate

   logic [WIDTH-1:0] prev_q;
   logic             armed_q;
   logic [NPTS-1:0]  covered_q;
   logic [NPTS-1:0]  valid_q;
   logic [CNT_W-1:0] covered_cnt_q;
   logic             all_covered_q;

   logic [NPTS-1:0]  ev;
   logic [NPTS-1:0]  new_hits;
   logic [CNT_W-1:0] cnt_next;

   // Even point = rise, odd point = fall; nothing counts until armed.
   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_edge
         assign ev[2*i]   = armed_q & ~prev_q[i] &  bus.sig[i];
         assign ev[2*i+1] = armed_q &  prev_q[i] & ~bus.sig[i];
      end
   endgenerate

   assign new_hits = ev & ~covered_q;
   assign cnt_next = covered_cnt_q + CNT_W'($countones(new_hits));

   always_ff @(posedge gbl_clk) begin
      if (!reset) begin
         prev_q        <= '0;
         armed_q       <= 1'b0;
         covered_q     <= '0;
         valid_q       <= '0;
         covered_cnt_q <= '0;
         all_covered_q <= 1'b0;
      end else begin
         prev_q  <= bus.sig;
         armed_q <= 1'b1;
         if (bus.clear) begin
            covered_q     <= '0;
            valid_q       <= '0;
            covered_cnt_q <= '0;
            all_covered_q <= 1'b0;
         end else begin
            covered_q     <= covered_q | new_hits;
            valid_q       <= new_hits;
            covered_cnt_q <= cnt_next;
            all_covered_q <= (cnt_next == CNT_W'(NPTS));
         end
      end
   end

   assign bus.valid       = valid_q;
   assign bus.covered_cnt = covered_cnt_q;
   assign bus.all_covered = all_covered_q;

`ifdef TOGGLE_INDEX_STREAM_EN
   logic [NPTS-1:0]  pending_q;
   logic             idx_valid_q;
   logic [63:0]      idx_q;

   logic [NPTS-1:0]  pend_lowest;
   logic [POS_W-1:0] pend_pos;
   logic             pend_any;
   logic             load;

   always_comb begin
      pend_pos = '0;
      for (int k = NPTS - 1; k >= 0; k--) begin
         if (pending_q[k]) begin
            pend_pos = POS_W'(k);
         end
      end
   end

   assign pend_lowest = pending_q & (~pending_q + 1'b1);
   assign pend_any    = |pending_q;
   assign load        = ~idx_valid_q | bus.idx_ready;

   // A newly hit point was not pending, so draining and setting never collide.
   always_ff @(posedge gbl_clk) begin
      if (!reset) begin
         pending_q   <= '0;
         idx_valid_q <= 1'b0;
         idx_q       <= '0;
      end else if (bus.clear) begin
         pending_q   <= '0;
         idx_valid_q <= 1'b0;
      end else if (load) begin
         pending_q   <= (pending_q & ~pend_lowest) | new_hits;
         idx_valid_q <= pend_any;
         if (pend_any) begin
            idx_q <= COVER_INDEX + 64'(pend_pos);
         end
      end else begin
         pending_q <= pending_q | new_hits;
      end
   end

   assign bus.idx_valid = idx_valid_q;
   assign bus.idx       = idx_q;
`else
   logic unused_idx_ready;
   assign unused_idx_ready = bus.idx_ready;
   assign bus.idx_valid    = 1'b0;
   assign bus.idx          = 64'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_toggle_edge_collector.sv
`default_nettype none
// Scoreboarded random/directed bench for toggle_edge_collector; the reference
// model tracks covered/pending point sets and the held output index.
module tb_toggle_edge_collector;
   localparam int          WIDTH = 52;
   localparam int          NPTS  = 2 * WIDTH;
   localparam int          CNT_W = $clog2(NPTS + 1);
   localparam logic [63:0] CI    = 64'd100;
`ifdef TOGGLE_INDEX_STREAM_EN
   localparam bit STREAM = 1'b1;
`else
   localparam bit STREAM = 1'b0;
`endif

   typedef struct packed {
      logic [NPTS-1:0]  v;
      logic [CNT_W-1:0] cnt;
      logic             all;
      logic             iv;
      logic [63:0]      idx;
   } exp_t;

   logic gbl_clk = 1'b0;
   logic reset   = 1'b0;
   always #5 gbl_clk = ~gbl_clk;

   toggle_edge_collector_if #(.WIDTH(WIDTH)) bus ();

   toggle_edge_collector #(
      .WIDTH      (WIDTH),
      .COVER_INDEX(CI),
      .COVER_TOTAL(64'd28338)
   ) dut (
      .gbl_clk(gbl_clk),
      .reset  (reset),
      .bus    (bus)
   );

   int total = 0;
   int bad   = 0;
   exp_t sbq[$];

   // reference model state
   logic [WIDTH-1:0] m_prev  = '0;
   bit               m_armed = 0;
   logic [NPTS-1:0]  m_cov   = '0;
   logic [NPTS-1:0]  m_pend  = '0;
   bit               m_ov    = 0;
   logic [63:0]      m_idx   = '0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, req);
      end
   endtask

   task automatic step(input logic [WIDTH-1:0] s, input bit clr, input bit rdy, input bit rstn);
      logic [NPTS-1:0] ev;
      logic [NPTS-1:0] nw;
      exp_t e;
      int p;
      @(negedge gbl_clk);
      bus.sig       = s;
      bus.clear     = clr;
      bus.idx_ready = rdy;
      reset         = rstn;
      e = '0;
      if (!rstn) begin
         m_prev = '0; m_armed = 0; m_cov = '0; m_pend = '0; m_ov = 0; m_idx = '0;
      end else begin
         ev = '0;
         for (int i = 0; i < WIDTH; i++) begin
            ev[2*i]   = m_armed && !m_prev[i] && s[i];
            ev[2*i+1] = m_armed && m_prev[i] && !s[i];
         end
         nw = ev & ~m_cov;
         if (clr) begin
            m_cov = '0; m_pend = '0; m_ov = 0;
         end else begin
            e.v = nw;
            if (STREAM && (!m_ov || rdy)) begin
               p = -1;
               for (int k = 0; k < NPTS; k++) if (m_pend[k] && p < 0) p = k;
               if (p >= 0) begin
                  m_ov = 1; m_idx = CI + 64'(p); m_pend[p] = 1'b0;
               end else begin
                  m_ov = 0;
               end
            end
            if (STREAM) m_pend = m_pend | nw;
            m_cov = m_cov | nw;
         end
         m_prev = s; m_armed = 1;
      end
      e.cnt = CNT_W'($countones(m_cov));
      e.all = ($countones(m_cov) == NPTS);
      e.iv  = m_ov;
      e.idx = m_idx;
      sbq.push_back(e);
   endtask

   exp_t me;
   always begin
      @(posedge gbl_clk);
      #1;
      if (sbq.size() > 0) begin
         me = sbq.pop_front();
         chk("valid", 128'(bus.valid), 128'(me.v));
         chk("covered_cnt", 128'(bus.covered_cnt), 128'(me.cnt));
         chk("all_covered", 128'(bus.all_covered), 128'(me.all));
         chk("idx_valid", 128'(bus.idx_valid), 128'(me.iv));
         if (me.iv || !STREAM) chk("idx", 128'(bus.idx), 128'(me.idx));
      end
   end

   logic [WIDTH-1:0] cur;
   logic [WIDTH-1:0] one;

   initial begin
      bus.sig = '0; bus.clear = 0; bus.idx_ready = 1;
      one = 1;
      // arming with sig held high through reset release
      repeat (3) step(52'h1, 0, 1, 0);
      repeat (10) step(52'h1, 0, 1, 1);
      // single bit rise, fall, repeat rise
      repeat (2) step('0, 0, 1, 0);
      repeat (3) step('0, 0, 1, 1);
      repeat (4) step(52'h8, 0, 1, 1);
      repeat (3) step('0, 0, 1, 1);
      repeat (4) step(52'h8, 0, 1, 1);
      // simultaneous rises under backpressure
      repeat (2) step('0, 0, 1, 0);
      repeat (3) step('0, 0, 1, 1);
      repeat (5) step(52'hF, 0, 0, 1);
      repeat (6) step(52'hF, 0, 1, 1);
      // full coverage
      repeat (120) step('1, 0, 1, 1);
      repeat (120) step('0, 0, 1, 1);
      // clear mid-drain, then re-fire
      repeat (2) step('0, 0, 0, 0);
      repeat (3) step('0, 0, 0, 1);
      repeat (4) step(52'h7, 0, 0, 1);
      step(52'h7, 1, 0, 1);
      repeat (3) step(52'h7, 0, 1, 1);
      repeat (2) step('0, 0, 1, 1);
      repeat (6) step(52'h7, 0, 1, 1);
      // reset mid-drain, first sample after reset ignored
      repeat (3) step('0, 0, 0, 1);
      repeat (3) step(52'h7, 0, 0, 1);
      step(52'h7, 0, 0, 0);
      repeat (4) step(52'h7, 0, 1, 1);
      repeat (3) step('0, 0, 1, 1);
      // random traffic
      cur = '0;
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 2) == 0) cur = cur ^ (one << $urandom_range(0, WIDTH - 1));
         if ($urandom_range(0, 9) == 0) cur = cur ^ WIDTH'({$urandom, $urandom});
         step(cur, $urandom_range(0, 80) == 0, $urandom_range(0, 2) != 0,
              $urandom_range(0, 250) != 0);
      end
      repeat (20) step(cur, 0, 1, 1);
      @(negedge gbl_clk);
      @(negedge gbl_clk);
      chk("scoreboard_empty", 128'(sbq.size()), 128'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
